// File: rtl/vga_pattern_gen.sv
// VGA sync timing and eight-way test-pattern generator with one registered output stage.
// mode is sampled only at frame end, so a pattern change never lands mid-frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COLOR_W   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int HW        = 11,
  parameter int VW        = 10
) (
  input  logic               clk_main,
  input  logic               rst,
  input  logic [2:0]         mode,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic [HW-1:0]      hcount_o,
  output logic [VW-1:0]      vcount_o,
  output logic               frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam logic [COLOR_W-1:0] C_MAX  = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_ZERO = '0;

  // One extra bit so window ends equal to the total never wrap.
  typedef logic [HW:0] hx_t;
  typedef logic [VW:0] vx_t;

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [2:0]    r_mode_q;
  logic [HW-1:0] r_bar_x;

  logic               w_h_last, w_frame_end, w_active;
  logic               w_hs_win, w_vs_win, w_in_bar, w_border, w_checker;
  logic [2:0]         w_idx;
  logic [HW-1:0]      w_bar_next;
  logic [COLOR_W-1:0] w_r, w_g, w_b;

  assign w_h_last    = (r_h == HW'(H_TOTAL - 1));
  assign w_frame_end = w_h_last && (r_v == VW'(V_TOTAL - 1));
  assign w_active    = ({1'b0, r_h} < hx_t'(H_ACTIVE)) && ({1'b0, r_v} < vx_t'(V_ACTIVE));
  assign w_hs_win    = ({1'b0, r_h} >= hx_t'(H_ACTIVE + H_FP)) &&
                       ({1'b0, r_h} <  hx_t'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_win    = ({1'b0, r_v} >= vx_t'(V_ACTIVE + V_FP)) &&
                       ({1'b0, r_v} <  vx_t'(V_ACTIVE + V_FP + V_SYNC));
  assign w_in_bar    = ({1'b0, r_h} >= {1'b0, r_bar_x}) &&
                       ({1'b0, r_h} <  ({1'b0, r_bar_x} + hx_t'(16)));
  assign w_border    = (r_h == '0) || (r_h == HW'(H_ACTIVE - 1)) ||
                       (r_v == '0) || (r_v == VW'(V_ACTIVE - 1));
  assign w_checker   = r_h[5] ^ r_v[5];
  assign w_bar_next  = (({1'b0, r_bar_x} + hx_t'(4)) > hx_t'(H_ACTIVE - 16)) ? '0
                                                                              : r_bar_x + HW'(4);

  always_ff @(posedge clk_main or negedge rst) begin
    if (!rst) begin
      r_h      <= '0;
      r_v      <= '0;
      r_mode_q <= '0;
      r_bar_x  <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + HW'(1);
      if (w_h_last) begin
        r_v <= (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + VW'(1);
      end
      if (w_frame_end) begin
        r_mode_q <= mode;
        r_bar_x  <= w_bar_next;
      end
    end
  end

  // Colour-bar index by threshold compare, avoiding a divider.
  always_comb begin
    w_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, r_h} >= hx_t'(k * BAR_W)) w_idx = 3'(k);
    end
  end

  always_comb begin
    w_r = C_ZERO;
    w_g = C_ZERO;
    w_b = C_ZERO;
    case (r_mode_q)
      3'd1: begin w_r = C_MAX; w_g = C_MAX; w_b = C_MAX; end
      3'd2: begin
        w_r = {COLOR_W{~w_idx[1]}};
        w_g = {COLOR_W{~w_idx[2]}};
        w_b = {COLOR_W{~w_idx[0]}};
      end
      3'd3: if (w_checker) begin w_r = C_MAX; w_g = C_MAX; w_b = C_MAX; end
      3'd4: begin
        w_r = r_h[COLOR_W+3:4]; w_g = r_h[COLOR_W+3:4]; w_b = r_h[COLOR_W+3:4];
      end
      3'd5: begin
        w_r = r_v[COLOR_W+3:4]; w_g = r_v[COLOR_W+3:4]; w_b = r_v[COLOR_W+3:4];
      end
      3'd6: begin
        w_b = C_MAX;
        if (w_in_bar) begin w_r = C_MAX; w_g = C_MAX; end
      end
      3'd7: if (w_border) begin w_r = C_MAX; w_g = C_MAX; w_b = C_MAX; end
      default: ;
    endcase
    if (!w_active) begin
      w_r = C_ZERO;
      w_g = C_ZERO;
      w_b = C_ZERO;
    end
  end

  always_ff @(posedge clk_main or negedge rst) begin
    if (!rst) begin
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      de_o          <= 1'b0;
      hcount_o      <= '0;
      vcount_o      <= '0;
      frame_start_o <= 1'b0;
    end else begin
      red_o         <= w_r;
      green_o       <= w_g;
      blue_o        <= w_b;
      hsync_o       <= w_hs_win ? HSYNC_POL : ~HSYNC_POL;
      vsync_o       <= w_vs_win ? VSYNC_POL : ~VSYNC_POL;
      de_o          <= w_active;
      hcount_o      <= r_h;
      vcount_o      <= r_v;
      frame_start_o <= (r_h == '0) && (r_v == '0);
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster; a behavioural pixel model feeds an
// expected queue that each scenario task pops and compares every cycle.
module tb_vga_pattern_gen;

  localparam int HA = 64, HF = 2, HS = 4, HB = 2;
  localparam int VA = 34, VF = 1, VS = 2, VB = 1;
  localparam int CW = 4, HW = 8, VW = 8;
  localparam bit HPOL = 1'b0, VPOL = 1'b1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int MAXV = (1 << CW) - 1;
  localparam int EW = 3 * CW + 4 + HW + VW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] mode = 3'd3;
  logic [CW-1:0] red_o, green_o, blue_o;
  logic hsync_o, vsync_o, de_o, frame_start_o;
  logic [HW-1:0] hcount_o;
  logic [VW-1:0] vcount_o;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] w_act;
  int checks = 0;
  int errors = 0;

  int m_h, m_v, m_bar;
  logic [2:0] m_mode;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(CW), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .HW(HW), .VW(VW)
  ) dut (
    .clk_main(clk), .rst(rst), .mode(mode),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .hcount_o(hcount_o), .vcount_o(vcount_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  assign w_act = {red_o, green_o, blue_o, hsync_o, vsync_o, de_o, frame_start_o, hcount_o, vcount_o};

  function automatic logic [2:0] bar_rgb(int idx);
    case (idx)
      0: return 3'b111;  // white
      1: return 3'b110;  // yellow
      2: return 3'b011;  // cyan
      3: return 3'b010;  // green
      4: return 3'b101;  // magenta
      5: return 3'b100;  // red
      6: return 3'b001;  // blue
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [EW-1:0] model_pixel(int h, int v, logic [2:0] md, int bar);
    int r = 0, g = 0, b = 0;
    logic [2:0] c;
    logic act, hs, vs;
    act = (h < HA) && (v < VA);
    case (md)
      3'd1: begin r = MAXV; g = MAXV; b = MAXV; end
      3'd2: begin
        c = bar_rgb(h / (HA / 8));
        r = c[2] ? MAXV : 0; g = c[1] ? MAXV : 0; b = c[0] ? MAXV : 0;
      end
      3'd3: if (((h / 32) % 2) != ((v / 32) % 2)) begin r = MAXV; g = MAXV; b = MAXV; end
      3'd4: begin r = (h / 16) % (MAXV + 1); g = r; b = r; end
      3'd5: begin r = (v / 16) % (MAXV + 1); g = r; b = r; end
      3'd6: begin
        b = MAXV;
        if (h >= bar && h < bar + 16) begin r = MAXV; g = MAXV; end
      end
      3'd7: if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin r = MAXV; g = MAXV; b = MAXV; end
      default: ;
    endcase
    if (!act) begin r = 0; g = 0; b = 0; end
    hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
    vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : !VPOL;
    return {CW'(r), CW'(g), CW'(b), hs, vs, act, (h == 0 && v == 0), HW'(h), VW'(v)};
  endfunction

  // Reference raster: pushes the pixel the DUT must present after this edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_h <= 0; m_v <= 0; m_mode <= 3'd0; m_bar <= 0;
    end else begin
      exp_q.push_back(model_pixel(m_h, m_v, m_mode, m_bar));
      if (m_h == HT - 1) begin
        m_h <= 0;
        if (m_v == VT - 1) begin
          m_v    <= 0;
          m_mode <= mode;
          m_bar  <= (m_bar + 4 > HA - 16) ? 0 : m_bar + 4;
        end else begin
          m_v <= m_v + 1;
        end
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  task automatic step(output logic [EW-1:0] e);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset;
    logic [EW-1:0] e;
    rst = 1'b0;
    mode = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({red_o, green_o, blue_o} !== '0) begin
      errors++; $display("FAIL reset_rgb: got %h want 000", {red_o, green_o, blue_o});
    end
    checks++;
    if ({de_o, frame_start_o, hcount_o, vcount_o} !== '0) begin
      errors++; $display("FAIL reset_ctrl: de=%b fs=%b h=%0d v=%0d want all 0", de_o, frame_start_o, hcount_o, vcount_o);
    end
    checks++;
    if ({hsync_o, vsync_o} !== {!HPOL, !VPOL}) begin
      errors++; $display("FAIL reset_sync: got %b%b want %b%b", hsync_o, vsync_o, !HPOL, !VPOL);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    step(e);
    checks++;
    if (w_act !== e) begin
      errors++; $display("FAIL release_px: got %h want %h", w_act, e);
    end
    checks++;
    if ({hcount_o, vcount_o, de_o, frame_start_o, red_o, green_o, blue_o} !== {16'h0, 2'b11, 12'h000}) begin
      errors++; $display("FAIL release_first: h=%0d v=%0d de=%b fs=%b rgb=%h want 0,0,1,1,000",
                         hcount_o, vcount_o, de_o, frame_start_o, {red_o, green_o, blue_o});
    end
  endtask

  task automatic test_timing;
    logic [EW-1:0] e;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, fs_at = -1, hs_first = -1, vs_first = -1;
    for (int i = 1; i <= FRAME; i++) begin
      step(e);
      checks++;
      if (w_act !== e) begin errors++; $display("FAIL timing_px: got %h want %h", w_act, e); end
      if (de_o) de_cnt++;
      if (hsync_o == HPOL) begin
        hs_cnt++;
        if (hs_first < 0 && vcount_o == 0) hs_first = hcount_o;
      end
      if (vsync_o == VPOL) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = vcount_o;
      end
      if (frame_start_o) begin fs_cnt++; fs_at = i; end
    end
    checks++;
    if (de_cnt != HA * VA) begin errors++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA); end
    checks++;
    if (hs_cnt != HS * VT) begin errors++; $display("FAIL hsync_count: got %0d want %0d", hs_cnt, HS * VT); end
    checks++;
    if (hs_first != HA + HF) begin errors++; $display("FAIL hsync_start: got %0d want %0d", hs_first, HA + HF); end
    checks++;
    if (vs_cnt != VS * HT) begin errors++; $display("FAIL vsync_count: got %0d want %0d", vs_cnt, VS * HT); end
    checks++;
    if (vs_first != VA + VF) begin errors++; $display("FAIL vsync_line: got %0d want %0d", vs_first, VA + VF); end
    checks++;
    if (fs_cnt != 1 || fs_at != FRAME) begin
      errors++; $display("FAIL frame_period: pulses=%0d at=%0d want 1 at %0d", fs_cnt, fs_at, FRAME);
    end
  endtask

  task automatic test_mode_latch;
    logic [EW-1:0] e;
    int n = 0;
    do begin
      step(e); n++;
      checks++;
      if (w_act !== e) begin errors++; $display("FAIL latch_pre_px: got %h want %h", w_act, e); end
    end while (vcount_o != 10 && n < FRAME);
    mode = 3'd1;
    n = 0;
    do begin
      step(e); n++;
      checks++;
      if (w_act !== e) begin errors++; $display("FAIL latch_px: got %h want %h", w_act, e); end
    end while (!frame_start_o && n < FRAME);
    checks++;
    if (!frame_start_o || {red_o, green_o, blue_o} !== 12'hFFF) begin
      errors++; $display("FAIL latch_white: fs=%b rgb=%h want 1 FFF", frame_start_o, {red_o, green_o, blue_o});
    end
    n = 0;
    do begin
      step(e); n++;
    end while (hcount_o != HA && n < HT);
    checks++;
    if ({de_o, red_o, green_o, blue_o} !== 13'h0) begin
      errors++; $display("FAIL latch_blank: de=%b rgb=%h at h=%0d want 0 000", de_o, {red_o, green_o, blue_o}, hcount_o);
    end
  endtask

  task automatic test_patterns;
    logic [EW-1:0] e;
    logic [12:0] want;
    int cur = 1, n;
    for (int m = 0; m < 8; m++) begin
      mode = 3'(m);
      n = 0;
      do begin
        step(e); n++;
        checks++;
        if (w_act !== e) begin errors++; $display("FAIL pattern%0d_px: got %h want %h", cur, w_act, e); end
        if (cur == 2 && vcount_o == 1 && !frame_start_o) begin
          want = 13'h1FFF;
          case (hcount_o)
            8'd0:  want = {1'b1, 12'hFFF};
            8'd8:  want = {1'b1, 12'hFF0};
            8'd16: want = {1'b1, 12'h0FF};
            8'd56: want = {1'b1, 12'h000};
            8'd64: want = {1'b0, 12'h000};
            default: ;
          endcase
          if (want != 13'h1FFF) begin
            checks++;
            if ({de_o, red_o, green_o, blue_o} !== want) begin
              errors++; $display("FAIL colour_bar h=%0d: got %h want %h", hcount_o, {de_o, red_o, green_o, blue_o}, want);
            end
          end
        end
      end while (!frame_start_o && n <= FRAME);
      checks++;
      if (!frame_start_o) begin errors++; $display("FAIL pattern_timeout: no frame start, want one within %0d", FRAME); end
      cur = m;
    end
  endtask

  task automatic test_moving_bar;
    logic [EW-1:0] e;
    int n, first, wcnt, prev = -1;
    logic wrapped = 1'b0;
    mode = 3'd6;
    n = 0;
    do begin step(e); n++; end while (!frame_start_o && n <= FRAME);
    for (int f = 0; f < 14; f++) begin
      first = -1; wcnt = 0; n = 0;
      do begin
        step(e); n++;
        checks++;
        if (w_act !== e) begin errors++; $display("FAIL bar_px: got %h want %h", w_act, e); end
        if (vcount_o == 1 && de_o && {red_o, green_o, blue_o} === 12'hFFF) begin
          if (first < 0) first = hcount_o;
          wcnt++;
        end
      end while (!frame_start_o && n <= FRAME);
      checks++;
      if (wcnt != 16) begin errors++; $display("FAIL bar_width: got %0d want 16", wcnt); end
      if (prev >= 0) begin
        checks++;
        if (first != ((prev + 4 > HA - 16) ? 0 : prev + 4)) begin
          errors++; $display("FAIL bar_step: got %0d after %0d", first, prev);
        end
        if (prev == HA - 16 && first == 0) wrapped = 1'b1;
      end
      prev = first;
    end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL bar_wrap: got no wrap want 48->0"); end
  endtask

  task automatic test_reset_mid;
    logic [EW-1:0] e;
    int n = 0, first = -1;
    do begin step(e); n++; end while (!(vcount_o == 20 && hcount_o == 30) && n <= FRAME);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({red_o, green_o, blue_o, de_o, frame_start_o, hcount_o, vcount_o} !== '0 ||
        {hsync_o, vsync_o} !== {!HPOL, !VPOL}) begin
      errors++; $display("FAIL midrst_outs: rgb=%h de=%b fs=%b h=%0d v=%0d", {red_o, green_o, blue_o},
                         de_o, frame_start_o, hcount_o, vcount_o);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    step(e);
    checks++;
    if (!frame_start_o || {red_o, green_o, blue_o} !== 12'h000 || w_act !== e) begin
      errors++; $display("FAIL midrst_first: got %h want %h", w_act, e);
    end
    for (int f = 0; f < 2; f++) begin
      n = 0;
      do begin
        step(e); n++;
        checks++;
        if (w_act !== e) begin errors++; $display("FAIL midrst_px: got %h want %h", w_act, e); end
        if (f == 1 && vcount_o == 1 && de_o && {red_o, green_o, blue_o} === 12'hFFF && first < 0) first = hcount_o;
      end while (!frame_start_o && n <= FRAME);
    end
    checks++;
    if (first != 4) begin errors++; $display("FAIL midrst_bar: got %0d want 4", first); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mode_latch();
    test_patterns();
    test_moving_bar();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator, the next generation of our VGA display top. It produces programmable-resolution sync timing, a data-enable, aligned pixel coordinates and COLOR_W-bit-per-channel RGB for eight selectable patterns, one of them animated. Pattern changes are frame-synchronous, so there is no tearing. The block sits directly behind the board pins: the switches drive `mode`, and the outputs drive the DAC/resistor ladder.

## Interface
- H_ACTIVE, 640, visible pixels per line; multiple of 16, >= 32
- H_FP, 16, horizontal front porch, clocks
- H_SYNC, 96, horizontal sync width, clocks
- H_BP, 48, horizontal back porch, clocks
- V_ACTIVE, 480, visible lines; >= 2
- V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical porch/sync/porch, lines
- COLOR_W, 4, bits per colour channel, 1..8
- HSYNC_POL, 0 / VSYNC_POL, 0, active sync level
- HW, 11 / VW, 10, counter widths; must hold H_TOTAL-1 / V_TOTAL-1 and be >= COLOR_W+4
- clk_main  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  3  pattern select; sampled once per frame
- red_o, green_o, blue_o  out  COLOR_W each  pixel colour
- hsync_o, vsync_o  out  1  sync outputs at the programmed polarity
- de_o  out  1  high during active pixels
- hcount_o  out  HW  x coordinate of the current output pixel
- vcount_o  out  VW  y coordinate of the current output pixel
- frame_start_o  out  1  one-cycle pulse coincident with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h counts 0..H_TOTAL-1 and wraps. v advances when h wraps, counts 0..V_TOTAL-1, and wraps.
- active = (h < H_ACTIVE) && (v < V_ACTIVE).
- Sync windows:
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - Outside the window, sync is at its inactive level (~POL).
- Frame end is h==H_TOTAL-1 && v==V_TOTAL-1. At frame end:
  - mode_q <= mode.
  - bar_x updates: if bar_x+4 > H_ACTIVE-16 then 0, else bar_x+4.
- Only mode_q is used for pixel generation. mode changes mid-frame have no visible effect until the next frame.
- Patterns (MAX = all ones, grey means r=g=b):
  - 0: black.
  - 1: white.
  - 2: eight vertical colour bars, each H_ACTIVE/8 wide. idx = bar number 0..7. r=~idx[1], g=~idx[2], b=~idx[0], each expanded to 0 or MAX. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - 3: checkerboard of 32-pixel squares; white when h[5]^v[5], else black.
  - 4: horizontal grey ramp, value h[COLOR_W+3:4].
  - 5: vertical grey ramp, value v[COLOR_W+3:4].
  - 6: moving bar; white for bar_x <= h < bar_x+16, else blue=MAX, r=g=0.
  - 7: border; white when h==0, h==H_ACTIVE-1, v==0 or v==V_ACTIVE-1, else black.
- Outside the active region, RGB = 0 regardless of mode.

## Timing
- Single registered output stage. All outputs at cycle n+1 reflect counter state (h,v) at cycle n.
- RGB, de_o, syncs, hcount_o, vcount_o and frame_start_o are mutually aligned; no skew between them.
- frame_start_o = 1 exactly when hcount_o==0 && vcount_o==0.
- The ramp, checker and bar computations must complete within one clock. No additional pipeline stages are permitted.
- Reset (rst low, asynchronous):
  - h, v = 0; mode_q = 0; bar_x = 0.
  - RGB = 0; de_o = 0; frame_start_o = 0; hcount_o = 0; vcount_o = 0.
  - hsync_o = ~HSYNC_POL; vsync_o = ~VSYNC_POL.
- First rising edge after rst goes high: outputs present pixel (0,0) with de_o=1 and frame_start_o=1, using mode_q=0 (black). The sampled `mode` is not used until the first frame end.
- Reset asserted mid-frame returns all state to reset values immediately. No partial-frame state survives.
- Line period is H_TOTAL clocks; frame period is H_TOTAL*V_TOTAL clocks exactly.

## Test plan
- Reset: hold rst low with mode=3 → all outputs at reset values, syncs high (POL=0). Release → next cycle hcount_o=0, vcount_o=0, de_o=1, frame_start_o=1, RGB=0.
- Default 640x480 timing: count cycles → hsync_o low for 96 clocks starting at hcount_o=656; line = 800 clocks; vsync_o low for lines 490–491; frame_start_o period 420000; de_o high 640 clocks per active line.
- Mode latch: set mode=1 at line 100 of frame 0 → frame 0 stays black; frame 1 pixel (0,0) is white (MAX on all channels). Blanking pixels remain 0.
- Colour bars (mode=2, COLOR_W=4): at hcount_o 0, 80, 160, 560 → RGB = FFF, FF0, 0FF, 000. At hcount_o 640 → 000 with de_o=0.
- Moving bar with small parameters (H_ACTIVE=64, V_ACTIVE=4, porches 1/2/1 horizontally, 1/1/1 vertically): bar_x steps 0, 4, ... 48, then wraps to 0 on the next frame. White only for 16 pixels starting at bar_x; blue elsewhere.
- Reset mid-frame (mode=6, bar_x=20, pulse rst low at h=300, v=200) → counters and bar_x return to 0. After release, the output at frame_start_o is black because mode_q=0.
